video_timing_counters: RTL

// - Free-running horizontal/vertical counter chain: discrete H (74107/7493 chain) and V counters as synchronous RTL.
// - Sits directly upstream of the video sync stage.
// - Supplies the H/V count taps (_16H, _32H, _64H, _4V, _8V, _16V, ...), HRESET_N and VRESET.
// - All logic runs on CLK_DRV; the pixel rate is a one-cycle enable strobe (PIX_EN).

---
 rtl/video_timing_pkg.sv | 24 ++
 rtl/mod_n_counter.sv | 29 ++
 rtl/video_timing_counters.sv | 78 +++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared constants and types for the H/V video timing counter chain.
//   - H_TOTAL_DEF / V_TOTAL_DEF : default pixels per line / lines per frame
//   - *_BIT                     : count-tap bit indices used by the sync stage
//   - hcnt_t / vcnt_t           : count types at the default widths
package video_timing_pkg;

  localparam int H_TOTAL_DEF = 455;
  localparam int V_TOTAL_DEF = 262;
  localparam int H_WIDTH_DEF = 9;
  localparam int V_WIDTH_DEF = 9;

  // Tap indices: bit n of a count is the (2**n) tap.
  localparam int H16_BIT = 4;
  localparam int H32_BIT = 5;
  localparam int H64_BIT = 6;
  localparam int V4_BIT  = 2;
  localparam int V8_BIT  = 3;
  localparam int V16_BIT = 4;

  typedef logic [H_WIDTH_DEF-1:0] hcnt_t;
  typedef logic [V_WIDTH_DEF-1:0] vcnt_t;

endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter
//   Enabled modulo-N up counter, 0..N-1.
//   - CLK_DRV : clock
//   - RESET   : async active-high reset, clears CNT
//   - EN      : advance one step on this edge
//   - CNT     : current count
//   - WRAP    : combinational terminal count; the next enabled edge returns CNT to 0
module mod_n_counter #(
  parameter int N = 455,
  parameter int W = 9
) (
  input  logic         CLK_DRV,
  input  logic         RESET,
  input  logic         EN,
  output logic [W-1:0] CNT,
  output logic         WRAP
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // >= rather than == so a corrupted out-of-range count still recovers.
  assign WRAP = (CNT >= LAST);

  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET)   CNT <= '0;
    else if (EN) CNT <= WRAP ? '0 : CNT + W'(1);
  end

endmodule

// File: rtl/video_timing_counters.sv
// video_timing_counters
//   Free-running horizontal/vertical counter chain feeding the video sync stage.
//   All state on CLK_DRV; the pixel rate is the one-cycle strobe PIX_EN.
//   - CLK_DRV, RESET (async active-high), PIX_EN
//   - HCNT / VCNT          : counts; bit n is the (2**n)H / (2**n)V tap
//   - HRESET / HRESET_N    : high for the pixel period where HCNT==0
//   - VRESET / VRESET_N    : high for the line where VCNT==0
//   - LINE_TICK            : one-cycle pulse on the enable that wraps HCNT
//   - FRAME_TICK           : one-cycle pulse on the enable that wraps HCNT and VCNT
module video_timing_counters
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int H_WIDTH = H_WIDTH_DEF,
  parameter int V_WIDTH = V_WIDTH_DEF
) (
  input  logic               CLK_DRV,
  input  logic               RESET,
  input  logic               PIX_EN,
  output logic [H_WIDTH-1:0] HCNT,
  output logic [V_WIDTH-1:0] VCNT,
  output logic               HRESET,
  output logic               HRESET_N,
  output logic               VRESET,
  output logic               VRESET_N,
  output logic               LINE_TICK,
  output logic               FRAME_TICK
);

  logic h_wrap, v_wrap, v_en;
  logic hreset_q, vreset_q, line_tick_q, frame_tick_q;

  // V steps on the same edge that wraps H, so there is no carry latency.
  assign v_en = PIX_EN & h_wrap;

  mod_n_counter #(.N(H_TOTAL), .W(H_WIDTH)) u_hcnt (
    .CLK_DRV (CLK_DRV),
    .RESET   (RESET),
    .EN      (PIX_EN),
    .CNT     (HCNT),
    .WRAP    (h_wrap)
  );

  mod_n_counter #(.N(V_TOTAL), .W(V_WIDTH)) u_vcnt (
    .CLK_DRV (CLK_DRV),
    .RESET   (RESET),
    .EN      (v_en),
    .CNT     (VCNT),
    .WRAP    (v_wrap)
  );

  // HRESET/VRESET track "count is now 0"; they are registered alongside the
  // counters rather than decoded so they come straight off a flop. Reset
  // leaves them low: the first pulse appears only after a full line/frame.
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      hreset_q     <= 1'b0;
      vreset_q     <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      line_tick_q  <= v_en;
      frame_tick_q <= v_en & v_wrap;
      if (PIX_EN) hreset_q <= h_wrap;
      if (v_en)   vreset_q <= v_wrap;
    end
  end

  // Each signal and its complement come from the same flop.
  assign HRESET     = hreset_q;
  assign HRESET_N   = ~hreset_q;
  assign VRESET     = vreset_q;
  assign VRESET_N   = ~vreset_q;
  assign LINE_TICK  = line_tick_q;
  assign FRAME_TICK = frame_tick_q;

endmodule
